// File: rtl/cplx_mult_pipe_if.sv
// Streaming handshake bundle for cplx_mult_pipe: input sample/weight side and result side.
// The slave modport is the multiplier's view; master is the upstream/downstream driver's view.
interface cplx_mult_pipe_if #(
    parameter int DW = 12,
    parameter int WW = 5,
    parameter int OW = 18
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data_i;
    logic signed [DW-1:0] in_data_q;
    logic signed [WW-1:0] in_w_i;
    logic signed [WW-1:0] in_w_q;
    logic                 in_conj;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_i;
    logic signed [OW-1:0] out_q;

    modport master (
        output in_valid, in_data_i, in_data_q, in_w_i, in_w_q, in_conj, out_ready,
        input  in_ready, out_valid, out_i, out_q
    );

    modport slave (
        input  in_valid, in_data_i, in_data_q, in_w_i, in_w_q, in_conj, out_ready,
        output in_ready, out_valid, out_i, out_q
    );
endinterface

// File: rtl/cplx_mult_pipe.sv
// 3-stage pipelined signed complex multiplier (optionally by conj(w)) with full backpressure.
// Define CPLX_MULT_RND_SAT_EN for round-half-up + saturation with sticky ovf; default truncates and wraps.
module cplx_mult_pipe #(
    parameter int DW    = 12,
    parameter int WW    = 5,
    parameter int SHIFT = 0,
    parameter int OW    = 18
) (
    input  logic               clk,
    input  logic               rstb,
    cplx_mult_pipe_if.slave    bus,
    output logic               ovf,
    input  logic               ovf_clr
);
    localparam int PW = DW + WW;
    localparam int SW = PW + 1;

    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

`ifdef CPLX_MULT_RND_SAT_EN
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [SW:0] RND     = (SHIFT > 0) ? ((SW+1)'(1) << RND_SH) : '0;
    localparam logic signed [SW:0] SAT_MAX = ((SW+1)'(1) << (OW-1)) - (SW+1)'(1);
    localparam logic signed [SW:0] SAT_MIN = ~SAT_MAX;

    // One guard bit above the sum so the rounding offset cannot wrap.
    function automatic logic signed [SW:0] rnd_shift(input logic signed [SW-1:0] s);
        logic signed [SW:0] t;
        t = (SW+1)'(s) + RND;
        return t >>> SHIFT;
    endfunction

    function automatic logic sat_hit(input logic signed [SW:0] t);
        return (t > SAT_MAX) || (t < SAT_MIN);
    endfunction

    function automatic logic signed [OW-1:0] saturate(input logic signed [SW:0] t);
        logic signed [SW:0] c;
        if (t > SAT_MAX)      c = SAT_MAX;
        else if (t < SAT_MIN) c = SAT_MIN;
        else                  c = t;
        return c[OW-1:0];
    endfunction
`else
    function automatic logic signed [OW-1:0] trunc_wrap(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] t;
        t = s >>> SHIFT;
        return t[OW-1:0];
    endfunction
`endif

    // ---- S0: input capture
    logic                 vld_p0;
    logic signed [DW-1:0] a_p0, b_p0;
    logic signed [WW-1:0] c_p0, d_p0;
    logic                 conj_p0;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)    vld_p0 <= 1'b0;
        else if (adv) vld_p0 <= bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (adv && bus.in_valid) begin
            a_p0    <= bus.in_data_i;
            b_p0    <= bus.in_data_q;
            c_p0    <= bus.in_w_i;
            d_p0    <= bus.in_w_q;
            conj_p0 <= bus.in_conj;
        end
    end

    // ---- S1: partial products
    logic                 vld_p1;
    logic signed [PW-1:0] ac_p1, bd_p1, ad_p1, bc_p1;
    logic                 conj_p1;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)    vld_p1 <= 1'b0;
        else if (adv) vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        if (adv && vld_p0) begin
            ac_p1   <= PW'(a_p0) * PW'(c_p0);
            bd_p1   <= PW'(b_p0) * PW'(d_p0);
            ad_p1   <= PW'(a_p0) * PW'(d_p0);
            bc_p1   <= PW'(b_p0) * PW'(c_p0);
            conj_p1 <= conj_p0;
        end
    end

    // ---- S2: sums, scaling, output registers
    logic signed [SW-1:0] sum_i_p2, sum_q_p2;
    logic signed [OW-1:0] res_i_p2, res_q_p2;

    always_comb begin
        if (conj_p1) begin
            sum_i_p2 = SW'(ac_p1) + SW'(bd_p1);
            sum_q_p2 = SW'(bc_p1) - SW'(ad_p1);
        end else begin
            sum_i_p2 = SW'(ac_p1) - SW'(bd_p1);
            sum_q_p2 = SW'(ad_p1) + SW'(bc_p1);
        end
    end

`ifdef CPLX_MULT_RND_SAT_EN
    logic signed [SW:0] scl_i_p2, scl_q_p2;
    logic               hit_p2;

    assign scl_i_p2 = rnd_shift(sum_i_p2);
    assign scl_q_p2 = rnd_shift(sum_q_p2);
    assign res_i_p2 = saturate(scl_i_p2);
    assign res_q_p2 = saturate(scl_q_p2);
    assign hit_p2   = sat_hit(scl_i_p2) || sat_hit(scl_q_p2);

    // A fresh saturation event overrides a simultaneous clear.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) ovf <= 1'b0;
        else       ovf <= (ovf && !ovf_clr) || (adv && vld_p1 && hit_p2);
    end
`else
    logic unused_ovf_clr;

    assign res_i_p2       = trunc_wrap(sum_i_p2);
    assign res_q_p2       = trunc_wrap(sum_q_p2);
    assign ovf            = 1'b0;
    assign unused_ovf_clr = ovf_clr;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            bus.out_valid <= 1'b0;
            bus.out_i     <= '0;
            bus.out_q     <= '0;
        end else if (adv) begin
            bus.out_valid <= vld_p1;
            if (vld_p1) begin
                bus.out_i <= res_i_p2;
                bus.out_q <= res_q_p2;
            end
        end
    end
endmodule
